// File: rtl/axistream_sort_checker_pkg.sv
// rtl/axistream_sort_checker_pkg.sv - shared sort constants: checker states, LFSR seed/taps, order polarity
// Contents:
//   chk_state_t         FIRST/BODY state encoding of the sort checker
//   LFSR_SEED/LFSR_TAPS 16-bit maximal-length LFSR (taps 16,14,13,11)
//   ORDER_*             ASCENDING parameter values, shared with the swapper stages
package axistream_sort_checker_pkg;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } chk_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Tap positions 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam bit ORDER_DESCENDING = 1'b0;
    localparam bit ORDER_ASCENDING  = 1'b1;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/axistream_sort_checker_lfsr16.sv
// rtl/axistream_sort_checker_lfsr16.sv - 16-bit Fibonacci LFSR used for pseudo-random backpressure
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset, loads LFSR_SEED
//   enable  in   advance one step per cycle when high
//   state   out  current 16-bit LFSR state
module lfsr16
    import axistream_sort_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= {state[14:0], lfsr_feedback(state)};
        end
    end

endmodule

// File: rtl/axistream_sort_checker.sv
// rtl/axistream_sort_checker.sv - stream sink checking adjacent-beat order and packet length
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   src_tvalid/tready/tdata/tlast  incoming packet stream
//   pkt_done                   one-cycle pulse per completed packet
//   pkt_ok, pkt_len            verdict and (saturating) length of last completed packet
//   pkt_cnt, err_cnt           saturating counts of completed and bad packets
// Build option: AXISTREAM_SORT_CHECKER_STALL_EN gates src_tready with an LFSR bit.
module axistream_sort_checker
    import axistream_sort_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter bit ASCENDING  = ORDER_DESCENDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  src_tvalid,
    output logic                  src_tready,
    input  logic [DATA_WIDTH-1:0] src_tdata,
    input  logic                  src_tlast,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    chk_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  bad_q, bad_d;
    logic                  started_q;
    logic                  accept, complete, order_err;

    // Ready only from the first edge after reset release, never from tvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

`ifdef AXISTREAM_SORT_CHECKER_STALL_EN
    logic [15:0] lfsr_state;

    lfsr16 u_lfsr16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .state  (lfsr_state)
    );

    assign src_tready = started_q & lfsr_state[0];
`else
    assign src_tready = started_q;
`endif

    assign accept   = src_tvalid & src_tready;
    assign complete = accept & src_tlast;

    // Equal neighbours are legal in both polarities.
    assign order_err = (ASCENDING == ORDER_ASCENDING) ? (src_tdata < prev_q)
                                                      : (src_tdata > prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (complete) begin
            state_d = ST_FIRST;
        end else if (accept) begin
            state_d = ST_BODY;
        end
    end

    // Per-beat verdict and length including the beat being accepted now.
    always_comb begin
        bad_d = 1'b0;
        len_d = len_q;
        case (state_q)
            ST_FIRST: begin
                bad_d = 1'b0;
                len_d = LEN_WIDTH'(1);
            end
            ST_BODY: begin
                bad_d = bad_q | order_err;
                len_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);
            end
            default: begin
                bad_d = 1'b0;
                len_d = len_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            len_q  <= '0;
            bad_q  <= 1'b0;
        end else if (accept) begin
            prev_q <= src_tdata;
            len_q  <= len_d;
            bad_q  <= bad_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_done <= 1'b0;
            pkt_ok   <= 1'b1;
            pkt_len  <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            pkt_done <= complete;
            if (complete) begin
                pkt_ok  <= !bad_d;
                pkt_len <= len_d;
                if (pkt_cnt != CNT_MAX) begin
                    pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                end
                if (bad_d && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axistream_sort_checker.sv
// tb/tb_axistream_sort_checker.sv - self-checking bench for axistream_sort_checker
module tb_axistream_sort_checker;

    typedef logic [7:0] beat_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        src_tvalid = 1'b0, src_tlast = 1'b0, src_tready;
    logic [7:0]  src_tdata = '0;
    logic        pkt_done, pkt_ok;
    logic [15:0] pkt_len, pkt_cnt, err_cnt;

    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [7:0]  s_tdata = '0;
    logic        s_done, s_ok;
    logic [3:0]  s_len;
    logic [15:0] s_cnt, s_err;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int cyc = 0;
    int exp_cnt = 0, exp_err = 0;
    int s_exp_cnt = 0, s_exp_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axistream_sort_checker u_dut (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata), .src_tlast(src_tlast),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    axistream_sort_checker #(.LEN_WIDTH(4), .ASCENDING(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(s_tvalid), .src_tready(s_tready), .src_tdata(s_tdata), .src_tlast(s_tlast),
        .pkt_done(s_done), .pkt_ok(s_ok), .pkt_len(s_len), .pkt_cnt(s_cnt), .err_cnt(s_err)
    );

    // Reference: a packet is ok when every neighbouring pair obeys the order.
    function automatic bit model_ok(input beat_q_t q, input bit asc);
        for (int i = 1; i < q.size(); i++) begin
            if (asc ? (q[i] < q[i-1]) : (q[i] > q[i-1])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_len(input int n, input int max_len);
        return (n > max_len) ? max_len : n;
    endfunction

    // Called and returns at a falling edge; returns on the falling edge after acceptance.
    task automatic send_beat(input bit sel, input logic [7:0] d, input logic l);
        bit acc;
        int guard;
        guard = 0;
        if (sel) begin s_tvalid = 1'b1; s_tdata = d; s_tlast = l; end
        else     begin src_tvalid = 1'b1; src_tdata = d; src_tlast = l; end
        do begin
            acc = sel ? s_tready : src_tready;
            if (!acc) stall_cycles++;
            @(negedge clk);
            guard++;
        end while (!acc && guard < 2000);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: tready never 1 within %0d cycles (required 1)", guard);
        end
    endtask

    task automatic send_packet(input bit sel, input beat_q_t q, input bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            send_beat(sel, q[i], (i == q.size() - 1));
            if (gaps && (i != q.size() - 1)) begin
                int n;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    if (sel) begin s_tvalid = 1'b0; s_tdata = 8'($urandom); end
                    else     begin src_tvalid = 1'b0; src_tdata = 8'($urandom); end
                    @(negedge clk);
                end
            end
        end
        if (sel) s_tvalid = 1'b0; else src_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", src_tready); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", pkt_done); end
        checks++; if (pkt_ok !== 1'b1) begin errors++; $display("FAIL reset_ok: got %b want 1", pkt_ok); end
        checks++; if (pkt_len !== 16'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", pkt_len); end
        checks++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", pkt_cnt, err_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", src_tready); end
        @(negedge clk);
`ifndef AXISTREAM_SORT_CHECKER_STALL_EN
        checks++; if (src_tready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", src_tready); end
`endif
    endtask

    task automatic test_ordered;
        beat_q_t q;
        q = '{8'd9, 8'd7, 8'd7, 8'd2};
        send_packet(1'b0, q, 1'b0);
        exp_cnt++;
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL ordered_done: got %b want 1", pkt_done); end
        checks++; if (pkt_ok !== 1'b1) begin errors++; $display("FAIL ordered_ok: got %b want 1", pkt_ok); end
        checks++; if (pkt_len !== 16'd4) begin errors++; $display("FAIL ordered_len: got %0d want 4", pkt_len); end
        checks++; if (pkt_cnt !== 16'(exp_cnt) || err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL ordered_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_cnt, exp_err); end
        @(negedge clk);
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", pkt_done); end
        checks++; if (pkt_ok !== 1'b1 || pkt_len !== 16'd4) begin errors++; $display("FAIL verdict_hold: got ok=%b len=%0d want ok=1 len=4", pkt_ok, pkt_len); end
    endtask

    task automatic test_violation_last;
        beat_q_t q;
        q = '{8'd9, 8'd7, 8'd8};
        send_packet(1'b0, q, 1'b0);
        exp_cnt++; exp_err++;
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b0) begin errors++; $display("FAIL viol_last_ok: got done=%b ok=%b want done=1 ok=0", pkt_done, pkt_ok); end
        checks++; if (pkt_len !== 16'd3) begin errors++; $display("FAIL viol_last_len: got %0d want 3", pkt_len); end
        checks++; if (pkt_cnt !== 16'(exp_cnt) || err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL viol_last_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_cnt, exp_err); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int t0;
        send_beat(1'b0, 8'd5, 1'b1);
        exp_cnt++;
        t0 = cyc;
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_len !== 16'd1) begin errors++; $display("FAIL single_beat: got done=%b ok=%b len=%0d want 1/1/1", pkt_done, pkt_ok, pkt_len); end
        send_beat(1'b0, 8'd3, 1'b0);
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL b2b_mid_done: got %b want 0", pkt_done); end
        send_beat(1'b0, 8'd4, 1'b1);
        src_tvalid = 1'b0;
        exp_cnt++; exp_err++;
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b0 || pkt_len !== 16'd2) begin errors++; $display("FAIL b2b_second: got done=%b ok=%b len=%0d want 1/0/2", pkt_done, pkt_ok, pkt_len); end
        checks++; if (pkt_cnt !== 16'(exp_cnt) || err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL b2b_cnts: got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_cnt, exp_err); end
`ifndef AXISTREAM_SORT_CHECKER_STALL_EN
        checks++; if (cyc - t0 !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want 2", cyc - t0); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        beat_q_t q;
        send_beat(1'b0, 8'd9, 1'b0);
        send_beat(1'b0, 8'd8, 1'b0);
        src_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0 || pkt_len !== 16'd0 || pkt_ok !== 1'b1 || pkt_done !== 1'b0) begin
            errors++; $display("FAIL async_reset_vals: got cnt=%0d err=%0d len=%0d ok=%b done=%b want 0/0/0/1/0", pkt_cnt, err_cnt, pkt_len, pkt_ok, pkt_done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL ready_in_reset: cycle %0d got %b want 0", i, src_tready); end
        end
        rst_n = 1'b1;
        exp_cnt = 0; exp_err = 0;
        s_exp_cnt = 0; s_exp_err = 0;
        @(negedge clk);
        q = '{8'd1};
        send_packet(1'b0, q, 1'b0);
        exp_cnt++;
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_len !== 16'd1 || pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL after_reset_pkt: got done=%b ok=%b len=%0d cnt=%0d err=%0d want 1/1/1/1/0", pkt_done, pkt_ok, pkt_len, pkt_cnt, err_cnt); end
        @(negedge clk);
    endtask

    task automatic test_saturation_polarity;
        beat_q_t q;
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'(i));
        send_packet(1'b1, q, 1'b0);
        s_exp_cnt++;
        checks++; if (s_done !== 1'b1 || s_ok !== 1'b1) begin errors++; $display("FAIL sat_ok: got done=%b ok=%b want 1/1", s_done, s_ok); end
        checks++; if (s_len !== 4'(model_len(q.size(), 15))) begin errors++; $display("FAIL sat_len: got %0d want %0d", s_len, model_len(q.size(), 15)); end
        @(negedge clk);
        q = '{8'd0, 8'd5, 8'd3};
        send_packet(1'b1, q, 1'b0);
        s_exp_cnt++; s_exp_err++;
        checks++; if (s_ok !== 1'b0 || s_len !== 4'd3) begin errors++; $display("FAIL asc_violation: got ok=%b len=%0d want 0/3", s_ok, s_len); end
        checks++; if (s_cnt !== 16'(s_exp_cnt) || s_err !== 16'(s_exp_err)) begin errors++; $display("FAIL asc_cnts: got %0d/%0d want %0d/%0d", s_cnt, s_err, s_exp_cnt, s_exp_err); end
        @(negedge clk);
        q = '{8'd4, 8'd4, 8'd200};
        send_packet(1'b1, q, 1'b0);
        checks++; if (s_ok !== 1'b1) begin errors++; $display("FAIL asc_equal_ok: got %b want 1", s_ok); end
        @(negedge clk);
    endtask

    task automatic test_stall;
        beat_q_t q;
        q = {};
        for (int i = 100; i >= 1; i--) q.push_back(8'(i));
        stall_cycles = 0;
        send_packet(1'b0, q, 1'b0);
        exp_cnt++;
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_len !== 16'd100) begin
            errors++; $display("FAIL stall_pkt: got done=%b ok=%b len=%0d want 1/1/100", pkt_done, pkt_ok, pkt_len); end
`ifdef AXISTREAM_SORT_CHECKER_STALL_EN
        checks++; if (stall_cycles == 0) begin errors++; $display("FAIL stall_toggle: got %0d stalled cycles want >0", stall_cycles); end
`else
        checks++; if (stall_cycles != 0) begin errors++; $display("FAIL no_stall: got %0d stalled cycles want 0", stall_cycles); end
`endif
        @(negedge clk);
    endtask

    task automatic test_random;
        beat_q_t q;
        bit      ok;
        int      n;
        int      v;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 12);
            q = {};
            v = $urandom_range(0, 255);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    q.push_back(8'(v));
                    v = v - $urandom_range(0, 3);
                    if (v < 0) v = 0;
                end else begin
                    q.push_back(8'($urandom));
                end
            end
            ok = model_ok(q, 1'b0);
            send_packet(1'b0, q, 1'b1);
            exp_cnt++;
            if (!ok) exp_err++;
            checks++; if (pkt_done !== 1'b1 || pkt_ok !== ok || pkt_len !== 16'(model_len(n, 65535))) begin
                errors++; $display("FAIL random_pkt%0d: got done=%b ok=%b len=%0d want 1/%b/%0d", p, pkt_done, pkt_ok, pkt_len, ok, n); end
            checks++; if (pkt_cnt !== 16'(exp_cnt) || err_cnt !== 16'(exp_err)) begin
                errors++; $display("FAIL random_cnts%0d: got %0d/%0d want %0d/%0d", p, pkt_cnt, err_cnt, exp_cnt, exp_err); end
            repeat ($urandom_range(0, 2)) begin
                src_tdata = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_violation_last();
        test_back_to_back();
        test_reset_mid();
        test_saturation_polarity();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
